// File: rtl/pipe_bp_pkg.sv
// pipe_bp_pkg: shared definitions for the pipelined MIPS branch-prediction unit.
//   - control-transfer kind encodings carried on up_kind
//   - a parameter-legality function checked at elaboration by the top
//   - saturating counter helpers (increment, decrement, initial value)
// Counter helpers work on int so they serve any CTR_W; callers cast back.
package pipe_bp_pkg;

  localparam logic [1:0] BK_BR   = 2'd0;  // conditional branch
  localparam logic [1:0] BK_JMP  = 2'd1;  // unconditional jump
  localparam logic [1:0] BK_RET  = 2'd2;  // jr $31
  localparam logic [1:0] BK_CALL = 2'd3;  // jal / jalr

  function automatic bit params_ok(input int addr_w, input int entries,
                                   input int tag_w, input int ctr_w,
                                   input int ras_depth);
    int idx_w;
    idx_w = $clog2(entries);
    return (entries >= 2) && ((1 << idx_w) == entries) &&
           (tag_w >= 1) && (2 + idx_w + tag_w <= addr_w) &&
           (ctr_w >= 1) && (ctr_w <= 30) && (ras_depth >= 1);
  endfunction

  function automatic int ctr_max(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int ctr_inc(input int c, input int w);
    return (c >= ctr_max(w)) ? c : c + 1;
  endfunction

  function automatic int ctr_dec(input int c);
    return (c <= 0) ? 0 : c - 1;
  endfunction

  // Fresh BR entries start weakly taken; other kinds are always taken.
  function automatic int ctr_init(input logic [1:0] kind, input int w);
    return (kind == BK_BR) ? (1 << (w - 1)) : ctr_max(w);
  endfunction

endpackage

// File: rtl/pipe_ras.sv
// pipe_ras: circular return-address stack.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the stack)
//   clear         empty the stack this edge (pointer and count to 0)
//   push          write push_data as new top; when full the oldest slot is
//                 overwritten and count stays RAS_DEPTH
//   pop           drop the top entry; ignored when empty
//   push_data     address to push
//   top           current top (meaningful only when count != 0)
//   count         occupancy, 0..RAS_DEPTH
// push and pop are never asserted together by the owner.
module pipe_ras #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_q;     // next slot to write; top lives one below
  logic [CNT_W-1:0]  count_q;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] wrap_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sp_q    <= '0;
      count_q <= '0;
    end else if (push) begin
      stack_q[sp_q] <= push_data;
      sp_q          <= wrap_inc(sp_q);
      if (count_q != CNT_W'(RAS_DEPTH)) count_q <= count_q + 1'b1;
    end else if (pop && (count_q != '0)) begin
      sp_q    <= wrap_dec(sp_q);
      count_q <= count_q - 1'b1;
    end
  end

  assign top   = stack_q[wrap_dec(sp_q)];
  assign count = count_q;

endmodule

// File: rtl/pipe_bpu_btb.sv
// pipe_bpu_btb: direct-mapped BTB with per-entry saturating counters and a
// return-address stack, for the pipelined MIPS integer unit.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   lk_pc        IF-stage PC; lk_hit/lk_taken/lk_target are purely
//                combinational from lk_pc and current state
//   up_*         resolved control transfer from ID. Handshake: up_valid is a
//                one-cycle strobe with no ready; each high cycle carries
//                exactly one resolved instruction and is consumed at that
//                edge. up_kind: 0 BR, 1 JMP, 2 RET, 3 CALL.
//   flush        invalidate all entries and empty the RAS; wins over up_valid
//   ras_count    current RAS occupancy
// Index = pc[2 +: IDX_W], tag = pc[2+IDX_W +: TAG_W].
module pipe_bpu_btb
  import pipe_bp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 8,
  parameter int CTR_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_W-1:0]                lk_pc,
  output logic                             lk_hit,
  output logic                             lk_taken,
  output logic [ADDR_W-1:0]                lk_target,
  input  logic                             up_valid,
  input  logic [ADDR_W-1:0]                up_pc,
  input  logic [1:0]                       up_kind,
  input  logic                             up_taken,
  input  logic [ADDR_W-1:0]                up_target,
  input  logic                             flush,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  if (!params_ok(ADDR_W, ENTRIES, TAG_W, CTR_W, RAS_DEPTH)) begin : g_bad_params
    $error("pipe_bpu_btb: illegal parameter combination");
  end

  // Storage is a flop array so flush clears every valid bit in one edge.
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [1:0]        kind_q   [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              up_hit;
  logic              up_alloc;
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_cnt;

  assign lk_idx = lk_pc[2 +: IDX_W];
  assign lk_tag = lk_pc[2 + IDX_W +: TAG_W];
  assign up_idx = up_pc[2 +: IDX_W];
  assign up_tag = up_pc[2 + IDX_W +: TAG_W];

  // ---------------- lookup (no flops on this path) ----------------
  always_comb begin
    lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken  = lk_hit && ((kind_q[lk_idx] != BK_BR) || ctr_q[lk_idx][CTR_W-1]);
    lk_target = lk_pc + ADDR_W'(4);
    if (lk_taken) begin
      if ((kind_q[lk_idx] == BK_RET) && (ras_cnt != '0)) lk_target = ras_top;
      else                                               lk_target = target_q[lk_idx];
    end
  end

  // ---------------- update ----------------
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  // A not-taken BR that misses never earns an entry.
  assign up_alloc = !((up_kind == BK_BR) && !up_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (up_valid) begin
      if (up_hit) begin
        if (up_kind == BK_BR) begin
          ctr_q[up_idx] <= up_taken ? CTR_W'(ctr_inc(int'(ctr_q[up_idx]), CTR_W))
                                    : CTR_W'(ctr_dec(int'(ctr_q[up_idx])));
          if (up_taken) target_q[up_idx] <= up_target;
        end else begin
          kind_q[up_idx]   <= up_kind;
          target_q[up_idx] <= up_target;
          ctr_q[up_idx]    <= CTR_W'(ctr_max(CTR_W));
        end
      end else if (up_alloc) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= up_target;
        kind_q[up_idx]   <= up_kind;
        ctr_q[up_idx]    <= CTR_W'(ctr_init(up_kind, CTR_W));
      end
    end
  end

  // ---------------- return-address stack ----------------
  // Non-speculative: only resolved CALL/RET move it, and flush drops the update.
  assign ras_push = up_valid && !flush && (up_kind == BK_CALL);
  assign ras_pop  = up_valid && !flush && (up_kind == BK_RET);

  pipe_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH),
    .CNT_W     (CNT_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (up_pc + ADDR_W'(4)),
    .top       (ras_top),
    .count     (ras_cnt)
  );

  assign ras_count = ras_cnt;

endmodule

// File: tb/tb_pipe_bpu_btb.sv
// Self-checking bench for pipe_bpu_btb: directed scenarios followed by random
// traffic, each cycle compared against a behavioural model of the BTB/RAS.
module tb_pipe_bpu_btb;

  localparam int ADDR_W    = 32;
  localparam int ENTRIES   = 16;
  localparam int TAG_W     = 8;
  localparam int CTR_W     = 2;
  localparam int RAS_DEPTH = 4;
  localparam int IDX_W     = $clog2(ENTRIES);
  localparam int CNT_W     = $clog2(RAS_DEPTH + 1);
  localparam int EXP_W     = 2 + ADDR_W + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] lk_pc = '0;
  logic              lk_hit, lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic              up_valid = 1'b0;
  logic [ADDR_W-1:0] up_pc = '0;
  logic [1:0]        up_kind = 2'd0;
  logic              up_taken = 1'b0;
  logic [ADDR_W-1:0] up_target = '0;
  logic              flush = 1'b0;
  logic [CNT_W-1:0]  ras_count;

  pipe_bpu_btb #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .TAG_W(TAG_W),
    .CTR_W(CTR_W), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
    .up_valid(up_valid), .up_pc(up_pc), .up_kind(up_kind),
    .up_taken(up_taken), .up_target(up_target),
    .flush(flush), .ras_count(ras_count)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                m_valid [ENTRIES];
  int                m_tag   [ENTRIES];
  logic [ADDR_W-1:0] m_tgt   [ENTRIES];
  int                m_kind  [ENTRIES];
  int                m_ctr   [ENTRIES];
  logic [ADDR_W-1:0] m_ras[$];   // back = most recent call

  function automatic int idx_of(input logic [ADDR_W-1:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [ADDR_W-1:0] pc);
    return int'((pc / (4 * ENTRIES)) % (1 << TAG_W));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
    m_ras.delete();
  endtask

  task automatic model_lookup(input logic [ADDR_W-1:0] pc, output logic [EXP_W-1:0] e);
    int  i;
    bit  h, t;
    logic [ADDR_W-1:0] tg;
    i  = idx_of(pc);
    h  = m_valid[i] && (m_tag[i] == tag_of(pc));
    // Counter in the upper half of its range means predict taken.
    t  = h && ((m_kind[i] != 0) || (m_ctr[i] >= (1 << (CTR_W - 1))));
    if (!t) tg = pc + 4;
    else if (m_kind[i] == 2 && m_ras.size() > 0) tg = m_ras[m_ras.size() - 1];
    else tg = m_tgt[i];
    e = {h, t, tg, CNT_W'(m_ras.size())};
  endtask

  task automatic model_update(input bit uv, input logic [ADDR_W-1:0] pc, input int kind,
                              input bit taken, input logic [ADDR_W-1:0] tgt, input bit fl);
    int i;
    int cmax;
    bit h;
    cmax = (1 << CTR_W) - 1;
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
      m_ras.delete();
      return;
    end
    if (!uv) return;
    i = idx_of(pc);
    h = m_valid[i] && (m_tag[i] == tag_of(pc));
    if (h) begin
      if (kind == 0) begin
        if (taken) begin
          m_ctr[i] = (m_ctr[i] < cmax) ? m_ctr[i] + 1 : cmax;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else begin
        m_kind[i] = kind;
        m_tgt[i]  = tgt;
        m_ctr[i]  = cmax;
      end
    end else if (!(kind == 0 && !taken)) begin
      m_valid[i] = 1;
      m_tag[i]   = tag_of(pc);
      m_tgt[i]   = tgt;
      m_kind[i]  = kind;
      m_ctr[i]   = (kind == 0) ? (1 << (CTR_W - 1)) : cmax;
    end
    if (kind == 3) begin
      m_ras.push_back(pc + 4);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end else if (kind == 2 && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge; drives one cycle, checks the lookup at
  // the falling edge (pre-update state), then lets the edge commit the update.
  task automatic step(input logic [ADDR_W-1:0] pc, input logic uv,
                      input logic [ADDR_W-1:0] upc, input logic [1:0] kind,
                      input logic taken, input logic [ADDR_W-1:0] tgt,
                      input logic fl);
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] got;
    lk_pc = pc; up_valid = uv; up_pc = upc; up_kind = kind;
    up_taken = taken; up_target = tgt; flush = fl;
    @(negedge clk);
    model_lookup(pc, e);
    exp_q.push_back(e);
    got = {lk_hit, lk_taken, lk_target, ras_count};
    e = exp_q.pop_front();
    check("lk_hit",    64'(got[EXP_W-1]),            64'(e[EXP_W-1]));
    check("lk_taken",  64'(got[EXP_W-2]),            64'(e[EXP_W-2]));
    check("lk_target", 64'(got[CNT_W +: ADDR_W]),    64'(e[CNT_W +: ADDR_W]));
    check("ras_count", 64'(got[CNT_W-1:0]),          64'(e[CNT_W-1:0]));
    @(posedge clk);
    model_update(uv, upc, int'(kind), taken, tgt, fl);
    #1;
    up_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic look(input logic [ADDR_W-1:0] pc);
    step(pc, 1'b0, '0, 2'd0, 1'b0, '0, 1'b0);
  endtask

  task automatic upd(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] upc,
                     input logic [1:0] kind, input logic taken, input logic [ADDR_W-1:0] tgt);
    step(pc, 1'b1, upc, kind, taken, tgt, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] rpc, rupc, rtgt;
    logic [1:0]        rkind;
    logic              rtaken, ruv, rfl;

    do_reset();

    // Reset state.
    look(32'h0040_0000);

    // BR taken allocates weak-taken; same-cycle lookup of that index sees old state.
    upd(32'h0040_0010, 32'h0040_0010, 2'd0, 1'b1, 32'h0040_0100);
    look(32'h0040_0010);
    // Three not-taken: 2 -> 1 -> 0 -> 0 (saturates), prediction falls through.
    for (int k = 0; k < 3; k++) upd(32'h0040_0010, 32'h0040_0010, 2'd0, 1'b0, 32'h0);
    look(32'h0040_0010);
    // One taken from 0 -> 1, still not taken.
    upd(32'h0040_0010, 32'h0040_0010, 2'd0, 1'b1, 32'h0040_0180);
    look(32'h0040_0010);

    // Aliasing index, different tag: evicts the first entry.
    upd(32'h0040_0050, 32'h0040_0050, 2'd0, 1'b1, 32'h0040_0300);
    look(32'h0040_0010);
    look(32'h0040_0050);

    // CALL x5 into a depth-4 RAS: count saturates at 4.
    for (int k = 0; k < 5; k++) upd(32'h0040_0020, 32'h0040_0020, 2'd3, 1'b1, 32'h0040_1000);
    look(32'h0040_0020);
    // RET entry allocation (also pops one), then lookups predict the RAS top.
    upd(32'h0040_0080, 32'h0040_0080, 2'd2, 1'b1, 32'h0040_0200);
    look(32'h0040_0080);
    for (int k = 0; k < 4; k++) upd(32'h0040_0080, 32'h0040_0080, 2'd2, 1'b1, 32'h0040_0200);
    look(32'h0040_0080);

    // Push and RET lookup in the same cycle: lookup sees old top/count.
    upd(32'h0040_0080, 32'h0040_0040, 2'd3, 1'b1, 32'h0040_2000);
    look(32'h0040_0080);

    // Flush with a same-cycle BR-taken update: dropped.
    step(32'h0040_0080, 1'b1, 32'h0040_0030, 2'd0, 1'b1, 32'h0040_0400, 1'b1);
    look(32'h0040_0030);
    look(32'h0040_0080);
    look(32'h0040_0020);

    // Random traffic over a small, heavily aliased PC pool.
    for (int n = 0; n < 800; n++) begin
      rpc   = 32'h0040_0000 | ADDR_W'($urandom_range(0, 3) << 6) | ADDR_W'($urandom_range(0, 15) << 2);
      rupc  = 32'h0040_0000 | ADDR_W'($urandom_range(0, 3) << 6) | ADDR_W'($urandom_range(0, 15) << 2);
      rkind = 2'($urandom_range(0, 3));
      rtaken = (rkind == 2'd0) ? 1'($urandom_range(0, 1)) : 1'b1;
      rtgt  = ADDR_W'($urandom) & ~32'h3;
      ruv   = ($urandom_range(0, 3) != 0);
      rfl   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) rpc = rupc;
      if (n == 400) begin
        do_reset();
        look(rpc);
      end
      step(rpc, ruv, rupc, rkind, rtaken, rtgt, rfl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
